dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_load_align.sv | 34 +++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
//   mem_size_t   : RV64I access size encoding (B/H/W/D)
//   dmem_state_t : responder FSM states
//   size_bytes() : access size in bytes
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [3:0] size_bytes(mem_size_t sz);
    case (sz)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: extracts the addressed bytes from a 64-bit memory
// word and sign- or zero-extends them to 64 bits.
//   i_word     : 64-bit word read from the store
//   i_offset   : byte offset of the access within the word
//   i_size     : access size (B/H/W/D)
//   i_unsigned : zero-extend instead of sign-extend (ignored for D)
//   o_data     : right-justified, extended load result
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic      [63:0] i_word,
  input  logic      [2:0]  i_offset,
  input  mem_size_t        i_size,
  input  logic             i_unsigned,
  output logic      [63:0] o_data
);

  logic [63:0] w_shifted;

  always_comb begin
    w_shifted = i_word >> {i_offset, 3'b000};
    o_data    = w_shifted;
    case (i_size)
      SZ_B: o_data = i_unsigned ? {56'h0, w_shifted[7:0]}
                                : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_data = i_unsigned ? {48'h0, w_shifted[15:0]}
                                : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W: o_data = i_unsigned ? {32'h0, w_shifted[31:0]}
                                : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's load/store interface.
// One request at a time over valid/ready; the response appears LATENCY
// cycles after acceptance and is held until the requester takes it.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_we/addr/wdata/size/unsigned : request fields, sampled at acceptance
//   resp_valid/resp_ready        : response handshake
//   resp_rdata                   : extended load data (0 for stores/errors)
//   resp_err                     : misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [63:0] r_mem [DEPTH_WORDS];

  dmem_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_enter_resp;

  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  mem_size_t   r_size;
  logic        r_unsigned;
  logic [63:0] r_rdata;
  logic        r_err;

  // With LATENCY=1 the array is accessed on the acceptance edge itself,
  // before the request fields are captured, so the access path takes the
  // live inputs while IDLE and the captured copy otherwise.
  logic        w_acc_we;
  logic [63:0] w_acc_addr;
  logic [63:0] w_acc_wdata;
  mem_size_t   w_acc_size;
  logic        w_acc_unsigned;

  logic             w_misalign;
  logic             w_oor;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [63:0]      w_word;
  logic [63:0]      w_load;
  logic [7:0]       w_lanes_base;
  logic [7:0]       w_lanes;
  logic [63:0]      w_wshift;
  logic [63:0]      w_merged;

  always_comb begin
    if (r_state == IDLE) begin
      w_acc_we       = req_we;
      w_acc_addr     = req_addr;
      w_acc_wdata    = req_wdata;
      w_acc_size     = mem_size_t'(req_size);
      w_acc_unsigned = req_unsigned;
    end else begin
      w_acc_we       = r_we;
      w_acc_addr     = r_addr;
      w_acc_wdata    = r_wdata;
      w_acc_size     = r_size;
      w_acc_unsigned = r_unsigned;
    end
  end

  always_comb begin
    case (w_acc_size)
      SZ_H:    w_misalign = w_acc_addr[0];
      SZ_W:    w_misalign = |w_acc_addr[1:0];
      SZ_D:    w_misalign = |w_acc_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  // DEPTH_WORDS is a power of two, so any set bit above the index field
  // means the word index is out of range.
  assign w_oor  = |w_acc_addr[63:3+IDX_W];
  assign w_err  = w_misalign | w_oor;
  assign w_idx  = w_acc_addr[3+IDX_W-1:3];
  assign w_word = r_mem[w_idx];

  dmem_load_align u_load_align (
    .i_word     (w_word),
    .i_offset   (w_acc_addr[2:0]),
    .i_size     (w_acc_size),
    .i_unsigned (w_acc_unsigned),
    .o_data     (w_load)
  );

  assign w_lanes_base = 8'((16'd1 << size_bytes(w_acc_size)) - 16'd1);
  assign w_lanes      = w_lanes_base << w_acc_addr[2:0];
  assign w_wshift     = w_acc_wdata << {w_acc_addr[2:0], 3'b000};

  always_comb begin
    w_merged = w_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_lanes[i]) w_merged[8*i +: 8] = w_wshift[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && req_valid) begin
        r_we       <= req_we;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= mem_size_t'(req_size);
        r_unsigned <= req_unsigned;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_acc_we) ? '0 : w_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_acc_we && !w_err) r_mem[w_idx] <= w_merged;
  end

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
